io_handshake_unit: RTL and testbench

- Device-side responder to the control unit's I/O instructions.
- When the core stalls on an input or output instruction (halt asserted with inputInst/outputInst), this block waits for an operator button press. It then supplies switch data (input) or latches register data to the display (output), and returns a one-cycle resume pulse that releases the stall.
- Sits between the control unit / writeback mux (MemToReg=2'b11 selects in_data) and the board switches, button and display.

---
 rtl/io_pkg.sv | 16 +
 rtl/button_conditioner.sv | 64 ++++++
 rtl/io_handshake_unit.sv | 91 +++++++++
 tb/tb_io_handshake_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the I/O handshake unit: FSM state encoding and the
// writeback-mux select value that routes in_data into the register file.
package io_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_IN  = 3'd1,
    WAIT_OUT = 3'd2,
    DONE     = 3'd3,
    COOL     = 3'd4
  } io_state_e;

  // MemToReg value that selects in_data as the writeback source.
  localparam logic [1:0] MEMTOREG_IN = 2'b11;

endpackage

// File: rtl/button_conditioner.sv
// Operator button front end: 2-flop synchroniser, optional debounce filter,
// and a registered rising-edge pulse. Optional macro: IO_DEBOUNCE_EN.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button,
  output logic btn_rise
);

  logic [1:0] sync_q;
  logic       level;
  logic       prev_q;
  logic       rise_q;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clock) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], button};
  end

`ifdef IO_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             filt_q;

  // Accept a level change only after it has persisted for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_q <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[1];
`endif

  // One-cycle pulse on a low-to-high transition of the conditioned level.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= level;
      rise_q <= level & ~prev_q;
    end
  end

  assign btn_rise = rise_q;

endmodule

// File: rtl/io_handshake_unit.sv
// Device-side responder for stalled input/output instructions. Waits for an
// operator button press, captures switches or latches the display, then
// pulses resume to release the core. Optional macro: IO_DEBOUNCE_EN
// (inserts a debounce filter in the button path).
module io_handshake_unit
  import io_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned SW_W            = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              inputInst,
  input  logic              outputInst,
  input  logic [DATA_W-1:0] out_data,
  input  logic [SW_W-1:0]   switches,
  input  logic              button,
  output logic [DATA_W-1:0] in_data,
  output logic              resume,
  output logic [DATA_W-1:0] display,
  output logic              waiting_input,
  output logic              waiting_output
);

  io_state_e         state_q;
  logic [DATA_W-1:0] in_q;
  logic [DATA_W-1:0] disp_q;
  logic [DATA_W-1:0] sw_ext;
  logic              btn_rise;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clock   (clock),
    .reset_n (reset_n),
    .button  (button),
    .btn_rise(btn_rise)
  );

  // Switches are zero-extended, or truncated when wider than the datapath.
  if (SW_W >= DATA_W) begin : g_sw_trunc
    assign sw_ext = switches[DATA_W-1:0];
  end else begin : g_sw_zext
    assign sw_ext = {{(DATA_W - SW_W){1'b0}}, switches};
  end

  // Handshake FSM plus the captured input and display registers.
  // A dropped request level (flush) abandons the wait with no update;
  // COOL gives the core one cycle to fetch past the old I/O instruction.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      in_q    <= '0;
      disp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inputInst)       state_q <= WAIT_IN;
          else if (outputInst) state_q <= WAIT_OUT;
        end
        WAIT_IN: begin
          if (!inputInst) begin
            state_q <= IDLE;
          end else if (btn_rise) begin
            in_q    <= sw_ext;
            state_q <= DONE;
          end
        end
        WAIT_OUT: begin
          if (!outputInst) begin
            state_q <= IDLE;
          end else if (btn_rise) begin
            disp_q  <= out_data;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= COOL;
        COOL:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_data        = in_q;
  assign display        = disp_q;
  assign resume         = (state_q == DONE);
  assign waiting_input  = (state_q == WAIT_IN);
  assign waiting_output = (state_q == WAIT_OUT);

endmodule

// File: tb/tb_io_handshake_unit.sv
// Scoreboard bench for io_handshake_unit: stimulus pushes the expected resume
// cycle and register contents; a negedge monitor pops on every resume.
module tb_io_handshake_unit;

`ifdef IO_DEBOUNCE_EN
  localparam int DB = 8;
`else
  localparam int DB = 0;
`endif
  localparam int DATA_W = 32;
  localparam int SW_W   = 16;

  logic              clock;
  logic              reset_n;
  logic              inputInst;
  logic              outputInst;
  logic [DATA_W-1:0] out_data;
  logic [SW_W-1:0]   switches;
  logic              button;
  logic [DATA_W-1:0] in_data;
  logic              resume;
  logic [DATA_W-1:0] display;
  logic              waiting_input;
  logic              waiting_output;

  io_handshake_unit #(
    .DATA_W(DATA_W),
    .SW_W(SW_W),
    .DEBOUNCE_CYCLES((DB == 0) ? 500000 : DB)
  ) dut (
    .clock(clock), .reset_n(reset_n), .inputInst(inputInst), .outputInst(outputInst),
    .out_data(out_data), .switches(switches), .button(button), .in_data(in_data),
    .resume(resume), .display(display), .waiting_input(waiting_input),
    .waiting_output(waiting_output)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [31:0] in_v;
    logic [31:0] disp_v;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic [31:0] exp_in;
  logic [31:0] exp_disp;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Monitor: every resume pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (resume === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resume: got resume=1 expected none (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        check("resume_cycle", cyc, e.cyc);
        check("in_data", in_data, e.in_v);
        check("display", display, e.disp_v);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // kind: 0 input, 1 output, 2 both (input wins). hold<0 keeps the request high.
  task automatic service(int kind, logic [15:0] sw, logic [31:0] od, int hold, int plen);
    bit seen;
    int i;
    switches   = sw;
    out_data   = od;
    inputInst  = (kind != 1);
    outputInst = (kind != 0);
    @(posedge clock);
    @(negedge clock);
    check("waiting_input", {31'd0, waiting_input}, {31'd0, kind != 1});
    check("waiting_output", {31'd0, waiting_output}, {31'd0, kind == 1});
    tick();
    button = 1'b1;
    if (kind == 1) exp_disp = od;
    else           exp_in   = {16'h0, sw};
    // Press seen by the FSM 3 edges later, resume in the state after that.
    sbq.push_back('{cyc + 4 + DB, exp_in, exp_disp});
    seen = 0;
    i    = 0;
    while ((!seen || button) && i < 60 + 2 * DB) begin
      @(negedge clock);
      if (resume === 1'b1) seen = 1;
      tick();
      i++;
      if (i == plen) button = 1'b0;
    end
    button = 1'b0;
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL resume_timeout: got no resume expected one (cycle %0d)", cyc);
    end
    if (hold >= 0) begin
      repeat (hold) tick();
      inputInst  = 1'b0;
      outputInst = 1'b0;
    end
    repeat (3 + 2 * DB) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; inputInst = 1'b0; outputInst = 1'b0;
    out_data = '0; switches = '0; button = 1'b0;
    exp_in = '0; exp_disp = '0;
    repeat (3) tick();
    @(negedge clock);
    check("rst_in_data", in_data, 32'h0);
    check("rst_display", display, 32'h0);
    check("rst_resume", {31'd0, resume}, 32'h0);
    check("rst_waiting", {30'd0, waiting_input, waiting_output}, 32'h0);
    tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // Basic input and output transactions.
    service(0, 16'h00A5, 32'h0, 0, 5 + DB);
    service(1, 16'hFFFF, 32'hDEADBEEF, 0, 2 + DB);
    @(negedge clock);
    check("display_hold", display, 32'hDEADBEEF);
    check("in_data_kept", in_data, 32'h000000A5);

    // Press with no request pending is discarded.
    tick();
    button = 1'b1;
    repeat (4 + DB) tick();
    button = 1'b0;
    repeat (4 + 2 * DB) tick();
    @(negedge clock);
    check("idle_press_waiting", {30'd0, waiting_input, waiting_output}, 32'h0);

    // Button already held when the request arrives: needs release and re-press.
    tick();
    button = 1'b1;
    repeat (5 + 2 * DB) tick();
    switches  = 16'h1234;
    inputInst = 1'b1;
    repeat (10) tick();
    @(negedge clock);
    check("held_btn_waiting", {31'd0, waiting_input}, 32'h1);
    tick();
    button = 1'b0;
    repeat (3 + 2 * DB) tick();
    service(0, 16'h1234, 32'h0, 0, 1 + DB);

    // Level held past COOL, then a back-to-back input instruction.
    service(0, 16'h0F0F, 32'h0, -1, 1 + DB);
    service(0, 16'h8001, 32'h0, 0, 1 + DB);

    // Lost request: output level drops mid-wait, nothing updates.
    out_data   = 32'h00000055;
    outputInst = 1'b1;
    repeat (2) tick();
    @(negedge clock);
    check("lost_waiting_out", {31'd0, waiting_output}, 32'h1);
    tick();
    outputInst = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    check("lost_back_idle", {31'd0, waiting_output}, 32'h0);
    check("lost_display", display, exp_disp);

    // Both levels high: input has priority.
    service(2, 16'hBEEF, 32'h11111111, 0, 1 + DB);

`ifdef IO_DEBOUNCE_EN
    // Short glitches must be filtered out.
    switches  = 16'h4242;
    inputInst = 1'b1;
    repeat (2) tick();
    for (int g = 1; g < DB; g++) begin
      button = 1'b1;
      repeat (g) tick();
      button = 1'b0;
      repeat (4) tick();
    end
    @(negedge clock);
    check("glitch_waiting", {31'd0, waiting_input}, 32'h1);
    tick();
    service(0, 16'h4242, 32'h0, 0, DB + 2);
`endif

    // Randomised transactions against the model.
    for (int t = 0; t < 20; t++) begin
      service(int'($urandom_range(0, 2)), 16'($urandom), $urandom,
              int'($urandom_range(0, 1)), DB + int'($urandom_range(1, 3)));
    end

    // Reset during WAIT_OUT with a press on the same cycle.
    out_data   = 32'hCAFEF00D;
    outputInst = 1'b1;
    repeat (3) tick();
    button     = 1'b1;
    reset_n    = 1'b0;
    outputInst = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    exp_in   = '0;
    exp_disp = '0;
    @(negedge clock);
    check("rst_mid_display", display, 32'h0);
    check("rst_mid_in_data", in_data, 32'h0);
    check("rst_mid_waiting", {30'd0, waiting_input, waiting_output}, 32'h0);
    repeat (5 + 2 * DB) tick();
    button = 1'b0;
    repeat (10 + 2 * DB) tick();
    check("scoreboard_empty", sbq.size(), 0);
    check("final_display", display, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
